// File: rtl/dmem_store_buffer.sv
// Posted-store buffer: stores queue in a small FIFO and drain to data memory in
// the background; loads wait for older stores, then make one round-trip.
module dmem_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_write_data,
   input  logic [3:0]        core_sign_mask,
   input  logic              core_memwrite,
   input  logic              core_memread,
   output logic [31:0]       core_read_data,
   output logic              core_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   output logic [3:0]        mem_sign_mask,
   output logic              mem_memwrite,
   output logic              mem_memread,
   input  logic [31:0]       mem_read_data,
   input  logic              mem_stall,
   output logic              sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        mask;
   } sb_entry_t;

   typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT, M_RESP} state_e;

   state_e            state_q, state_d;
   logic              is_load_q, is_load_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   sb_entry_t         fifo_q [DEPTH];
   sb_entry_t         fifo_d [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_write_data_q, mem_write_data_d;
   logic [3:0]        mem_sign_mask_q, mem_sign_mask_d;
   logic              mem_memwrite_q, mem_memwrite_d;
   logic              mem_memread_q, mem_memread_d;
   logic [31:0]       core_read_data_q, core_read_data_d;

   logic full, push, pop, start_load;
   sb_entry_t head;

   // Full uses the registered count: a same-edge pop does not free a slot.
   assign full = (count_q == CNT_W'(DEPTH));
   assign push = core_memwrite & ~core_memread & ~full;
   assign head = fifo_q[rd_ptr_q];

   always_comb begin
      state_d          = state_q;
      is_load_d        = is_load_q;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
      mem_sign_mask_d  = mem_sign_mask_q;
      mem_memwrite_d   = 1'b0;
      mem_memread_d    = 1'b0;
      core_read_data_d = core_read_data_q;
      pop              = 1'b0;
      start_load       = 1'b0;

      unique case (state_q)
         M_IDLE: begin
            if (count_q != '0) pop = 1'b1;
            else if (core_memread) start_load = 1'b1;
         end
         M_REQ: state_d = M_WAIT;
         M_WAIT: begin
            if (!mem_stall) begin
               if (is_load_q) begin
                  core_read_data_d = mem_read_data;
                  state_d          = M_RESP;
               end else if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = M_IDLE;
               end
            end
         end
         M_RESP: state_d = M_IDLE;
         default: state_d = M_IDLE;
      endcase

      if (pop) begin
         state_d          = M_REQ;
         is_load_d        = 1'b0;
         mem_addr_d       = head.addr;
         mem_write_data_d = head.data;
         mem_sign_mask_d  = head.mask;
         mem_memwrite_d   = 1'b1;
      end
      if (start_load) begin
         state_d         = M_REQ;
         is_load_d       = 1'b1;
         mem_addr_d      = core_addr;
         mem_sign_mask_d = core_sign_mask;
         mem_memread_d   = 1'b1;
      end
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{addr: core_addr, data: core_write_data, mask: core_sign_mask};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= M_IDLE;
         is_load_q        <= 1'b0;
         count_q          <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         fifo_q           <= '{default: '0};
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         mem_sign_mask_q  <= '0;
         mem_memwrite_q   <= 1'b0;
         mem_memread_q    <= 1'b0;
         core_read_data_q <= '0;
      end else begin
         state_q          <= state_d;
         is_load_q        <= is_load_d;
         count_q          <= count_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         fifo_q           <= fifo_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         mem_sign_mask_q  <= mem_sign_mask_d;
         mem_memwrite_q   <= mem_memwrite_d;
         mem_memread_q    <= mem_memread_d;
         core_read_data_q <= core_read_data_d;
      end
   end

   // A load stays stalled through drain and round-trip; it retires in M_RESP.
   assign core_stall     = (core_memwrite & full) | (core_memread & (state_q != M_RESP));
   assign sb_empty       = (count_q == '0) & (state_q == M_IDLE);
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_sign_mask  = mem_sign_mask_q;
   assign mem_memwrite   = mem_memwrite_q;
   assign mem_memread    = mem_memread_q;
   assign core_read_data = core_read_data_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer with a data-memory model and a
// program-order reference memory / expected-write queue.
module tb_dmem_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] core_addr = '0;
   logic [31:0] core_write_data = '0;
   logic [3:0]  core_sign_mask = '0;
   logic        core_memwrite = 1'b0;
   logic        core_memread = 1'b0;
   logic [31:0] core_read_data;
   logic        core_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [31:0] mem_read_data;
   logic        mem_stall;
   logic        sb_empty;

   dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .core_addr(core_addr), .core_write_data(core_write_data),
      .core_sign_mask(core_sign_mask), .core_memwrite(core_memwrite),
      .core_memread(core_memread), .core_read_data(core_read_data),
      .core_stall(core_stall), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_read_data(mem_read_data), .mem_stall(mem_stall),
      .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   // data memory: busy for mem_lat cycles after each request
   int          mem_lat = 2;
   int          left;
   logic [31:0] dmem [0:4095];

   function automatic int idx(input logic [31:0] a);
      return int'(a[13:2]);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_stall     <= 1'b0;
         left          <= 0;
         mem_read_data <= '0;
         for (int i = 0; i < 4096; i++) dmem[i] <= '0;
      end else begin
         if (mem_memwrite) dmem[idx(mem_addr)] <= mem_write_data;
         if (mem_memread) mem_read_data <= dmem[idx(mem_addr)];
         if (mem_memwrite | mem_memread) begin
            mem_stall <= 1'b1;
            left      <= mem_lat;
         end else if (left > 1) begin
            left <= left - 1;
         end else begin
            left      <= 0;
            mem_stall <= 1'b0;
         end
      end
   end

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } exp_t;

   int          total = 0, bad = 0;
   int          accepted = 0, pulses = 0, cyc = 0;
   exp_t        exp_q[$];
   int          pcyc[$];
   logic [31:0] ld_addr;
   logic [31:0] ref_mem [0:4095];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mon();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            exp_q.delete();
         end else begin
            if (mem_memwrite | mem_memread)
               chk("one_strobe", 64'(mem_memwrite & mem_memread), 0);
            if (mem_memwrite) begin
               pulses++;
               pcyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  chk("wr_extra", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", mem_addr, e.a);
                  chk("wr_data", mem_write_data, e.d);
                  chk("wr_mask", 64'(mem_sign_mask), 64'(e.m));
               end
            end
            if (mem_memread) begin
              chk("rd_addr", mem_addr, ld_addr);
              chk("rd_after_st", 64'(accepted - pulses), 0);
            end
         end
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int stalls);
      @(negedge clk);
      core_addr = a; core_write_data = d; core_sign_mask = m;
      core_memwrite = 1'b1; core_memread = 1'b0;
      #1 stalls = 0;
      while (1) begin
         chk("st_stall", 64'(core_stall), 64'((accepted - pulses) == DEPTH));
         chk("cnt_le_depth", 64'((accepted - pulses) <= DEPTH), 1);
         if (!core_stall || stalls >= 500) break;
         stalls++;
         @(negedge clk); #1;
      end
      chk("st_timeout", 64'(core_stall), 0);
      accepted++;
      exp_q.push_back('{a: a, d: d, m: m});
      ref_mem[idx(a)] = d;
      @(posedge clk); #1 core_memwrite = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, output int stalls);
      @(negedge clk);
      core_addr = a; ld_addr = a; core_sign_mask = 4'($urandom_range(0, 15));
      core_memread = 1'b1; core_memwrite = 1'b0;
      #1 stalls = 0;
      while (core_stall && stalls < 500) begin
         stalls++;
         @(negedge clk); #1;
      end
      chk("ld_timeout", 64'(core_stall), 0);
      chk("ld_data", core_read_data, ref_mem[idx(a)]);
      @(posedge clk); #1 core_memread = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      @(negedge clk); #1;
      while (!sb_empty && n < 300) begin
         n++;
         @(negedge clk); #1;
      end
      chk("empty_timeout", 64'(sb_empty), 1);
   endtask

   task automatic chk_reset_outs();
      chk("rst_mw", 64'(mem_memwrite), 0);
      chk("rst_mr", 64'(mem_memread), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wd", mem_write_data, 0);
      chk("rst_mask", 64'(mem_sign_mask), 0);
      chk("rst_rd", core_read_data, 0);
      chk("rst_empty", 64'(sb_empty), 1);
      chk("rst_stall", 64'(core_stall), 0);
   endtask

   initial begin
      int st, p0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
      fork mon(); join_none

      // power-on reset
      #12 chk_reset_outs();
      @(negedge clk) reset_n = 1'b1;

      // single store
      p0 = pulses;
      do_store(32'h1004, 32'hDEAD_BEEF, 4'b0100, st);
      chk("single_stall", 64'(st), 0);
      wait_empty();
      chk("single_pulses", 64'(pulses - p0), 1);

      // fill: DEPTH+2 back-to-back stores; only the last one sees a full buffer
      p0 = pcyc.size();
      for (int i = 1; i <= DEPTH + 2; i++) begin
         do_store(32'h1000 + 32'(4 * i), 32'(i), 4'b0010, st);
         chk("fill_stall", 64'(st), 64'(i == DEPTH + 2 ? 1 : 0));
      end
      wait_empty();
      chk("fill_count", 64'(pcyc.size() - p0), DEPTH + 2);
      for (int i = p0 + 1; i < pcyc.size(); i++)
         chk("fill_gap", 64'(pcyc[i] - pcyc[i-1]), 4);

      // load right behind a store
      do_store(32'h1010, 32'h0000_00A5, 4'b0010, st);
      do_load(32'h1010, st);
      chk("lds_data", core_read_data, 32'h0000_00A5);

      // plain load with an empty buffer
      do_store(32'h1020, 32'h1234_5678, 4'b0010, st);
      wait_empty();
      do_load(32'h1020, st);
      chk("ld_stalls", 64'(st), 5);
      chk("ld_value", core_read_data, 32'h1234_5678);

      // LED store
      do_store(32'h2000, 32'h0000_000F, 4'b0000, st);
      wait_empty();

      // wrap-around with interleaved drains
      for (int i = 0; i < 2 * DEPTH + 1; i++) begin
         do_store(32'h1000 + 32'(4 * (i % 8)), 32'h100 + 32'(i), 4'b0010, st);
         if (i % 3 == 2) wait_empty();
      end
      wait_empty();

      // reset mid-drain with three stores still buffered
      for (int i = 0; i < 4; i++)
         do_store(32'h1040 + 32'(4 * i), 32'h11 * 32'(i + 1), 4'b0010, st);
      chk("pre_rst_cnt", 64'(accepted - pulses), 3);
      @(negedge clk) reset_n = 1'b0;
      #1 chk_reset_outs();
      @(negedge clk); #1 chk_reset_outs();
      @(negedge clk) reset_n = 1'b1;
      accepted = pulses;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
      p0 = pulses;
      repeat (8) @(negedge clk);
      #1 chk("post_rst_empty", 64'(sb_empty), 1);
      chk("post_rst_pulses", 64'(pulses - p0), 0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         int r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         mem_lat = $urandom_range(1, 3);
         if (r < 6) do_store(a, $urandom, 4'($urandom_range(0, 15)), st);
         else if (r < 9) do_load(a, st);
         else repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_empty();
      chk("end_queue", 64'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1, "timeout");
   end
endmodule
